// File: rtl/alu_issue.sv
// alu_issue: operand/control stage in front of the 16-bit ALU.
// Decodes arithmetic-class instructions, reads operands from an 8x16
// register file, strobes the ALU, and writes its result back. It also
// handles IN, OUT and HLT. The cycle after accept (ISSUE) lets the
// operands settle before the registered alu_e rising edge.
module alu_issue #(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned DATA_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              illegal,
   output logic              halted,
   output logic              alu_e,
   output logic [3:0]        opcode,
   output logic [3:0]        d,
   output logic [DATA_W-1:0] alu_in_a,
   output logic [DATA_W-1:0] alu_in_b,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int unsigned REG_AW = 3;
   localparam int unsigned OP_W   = 4;

   localparam logic [OP_W-1:0] OP_CMP  = 4'b0101;
   localparam logic [OP_W-1:0] OP_R7   = 4'b0111;
   localparam logic [OP_W-1:0] OP_IN   = 4'b1100;
   localparam logic [OP_W-1:0] OP_OUT  = 4'b1101;
   localparam logic [OP_W-1:0] OP_R14  = 4'b1110;
   localparam logic [OP_W-1:0] OP_HLT  = 4'b1111;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      EXEC  = 3'd2,
      WB    = 3'd3,
      HALT  = 3'd4
   } state_t;

   state_t state, state_d;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [REG_AW-1:0] rd_q, rd_d;

   logic              alu_e_d, out_valid_d, illegal_d, halted_d, ready_d;
   logic [OP_W-1:0]   opcode_d;
   logic [3:0]        d_d;
   logic [DATA_W-1:0] a_d, b_d, out_data_d;
   logic              wr_en_c;

   logic              accept_c;
   logic [1:0]        f_cls_c;
   logic [REG_AW-1:0] f_rs_c, f_rd_c;
   logic [OP_W-1:0]   f_op_c;

   // Instruction field decode and handshake
   always_comb begin
      f_cls_c  = instr[15:14];
      f_rs_c   = instr[13:11];
      f_rd_c   = instr[10:8];
      f_op_c   = instr[7:4];
      accept_c = instr_valid & instr_ready;
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state;
      alu_e_d     = 1'b0;
      out_valid_d = 1'b0;
      illegal_d   = 1'b0;
      opcode_d    = opcode;
      d_d         = d;
      a_d         = alu_in_a;
      b_d         = alu_in_b;
      out_data_d  = out_data;
      rd_d        = rd_q;
      wr_en_c     = 1'b0;
      case (state)
         IDLE: begin
            if (accept_c) begin
               if (f_cls_c != 2'b11) begin
                  illegal_d = 1'b1;
               end else if (f_op_c == OP_HLT) begin
                  state_d = HALT;
               end else begin
                  state_d  = ISSUE;
                  opcode_d = f_op_c;
                  d_d      = instr[3:0];
                  b_d      = regs[f_rs_c];
                  a_d      = (f_op_c == OP_IN) ? in_data : regs[f_rd_c];
                  rd_d     = f_rd_c;
                  if (f_op_c == OP_OUT) out_data_d = regs[f_rs_c];
               end
            end
         end
         ISSUE: begin
            state_d = EXEC;
            alu_e_d = 1'b1;
         end
         EXEC: begin
            state_d     = WB;
            out_valid_d = (opcode == OP_OUT);
         end
         WB: begin
            state_d = IDLE;
            wr_en_c = !(opcode == OP_CMP || opcode == OP_R7 ||
                        opcode == OP_OUT || opcode == OP_R14);
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      halted_d = (state_d == HALT);
      ready_d  = (state_d == IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         instr_ready <= 1'b1;
         alu_e       <= 1'b0;
         out_valid   <= 1'b0;
         illegal     <= 1'b0;
         halted      <= 1'b0;
         opcode      <= '0;
         d           <= '0;
         alu_in_a    <= '0;
         alu_in_b    <= '0;
         out_data    <= '0;
         rd_q        <= '0;
      end else begin
         state       <= state_d;
         instr_ready <= ready_d;
         alu_e       <= alu_e_d;
         out_valid   <= out_valid_d;
         illegal     <= illegal_d;
         halted      <= halted_d;
         opcode      <= opcode_d;
         d           <= d_d;
         alu_in_a    <= a_d;
         alu_in_b    <= b_d;
         out_data    <= out_data_d;
         rd_q        <= rd_d;
      end
   end

   // Register file with ALU writeback on the edge leaving WB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      end else if (wr_en_c) begin
         regs[rd_q] <= alu_out;
      end
   end

   // Debug read port
   always_comb begin
      dbg_data = regs[dbg_addr];
   end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed test-plan sequence with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the issue stage and a small ALU model.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] in_data;
   logic [15:0] out_data;
   logic        out_valid;
   logic        illegal;
   logic        halted;
   logic        alu_e;
   logic [3:0]  opcode;
   logic [3:0]  d;
   logic [15:0] alu_in_a;
   logic [15:0] alu_in_b;
   logic [15:0] alu_out;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int n_cmp = 0;
   int n_bad = 0;

   alu_issue dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .in_data(in_data), .out_data(out_data),
      .out_valid(out_valid), .illegal(illegal), .halted(halted),
      .alu_e(alu_e), .opcode(opcode), .d(d), .alu_in_a(alu_in_a),
      .alu_in_b(alu_in_b), .alu_out(alu_out), .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural ALU: any deterministic function of the operands will do
   function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [3:0] sh,
                                          input logic [15:0] a, input logic [15:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd6:    return a << sh;
         4'd8:    return a >> sh;
         4'd9:    return ~a;
         4'd12:   return a;
         default: return a ^ b ^ {12'h000, op};
      endcase
   endfunction

   // ALU stand-in: computes on the rising edge of alu_e
   always @(posedge alu_e or posedge rst) begin
      if (rst) alu_out <= 16'h0000;
      else     alu_out <= alu_fn(opcode, d, alu_in_a, alu_in_b);
   end

   // Reference model: per accepted instruction, a 3-cycle timeline
   logic [15:0] m_regs [8];
   int          m_cnt;
   logic        m_halt, m_alu_e, m_ill, m_ov;
   logic [3:0]  m_op, m_d;
   logic [15:0] m_a, m_b, m_od, m_res;
   logic [2:0]  m_rd;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
         m_cnt <= 0; m_halt <= 1'b0; m_alu_e <= 1'b0; m_ill <= 1'b0; m_ov <= 1'b0;
         m_op <= 4'h0; m_d <= 4'h0; m_a <= 16'h0; m_b <= 16'h0; m_od <= 16'h0;
         m_res <= 16'h0; m_rd <= 3'd0;
      end else begin
         m_ill <= 1'b0; m_ov <= 1'b0; m_alu_e <= 1'b0;
         if (m_halt) begin
            m_cnt <= 0;
         end else if (m_cnt == 0) begin
            if (instr_valid) begin
               if (instr[15:14] != 2'b11) begin
                  m_ill <= 1'b1;
               end else if (instr[7:4] == 4'hF) begin
                  m_halt <= 1'b1;
               end else begin
                  m_op  <= instr[7:4];
                  m_d   <= instr[3:0];
                  m_rd  <= instr[10:8];
                  m_b   <= m_regs[instr[13:11]];
                  m_a   <= (instr[7:4] == 4'hC) ? in_data : m_regs[instr[10:8]];
                  m_res <= alu_fn(instr[7:4], instr[3:0],
                                  (instr[7:4] == 4'hC) ? in_data : m_regs[instr[10:8]],
                                  m_regs[instr[13:11]]);
                  if (instr[7:4] == 4'hD) m_od <= m_regs[instr[13:11]];
                  m_cnt <= 3;
               end
            end
         end else begin
            m_cnt <= m_cnt - 1;
            case (m_cnt)
               3: m_alu_e <= 1'b1;
               2: m_ov    <= (m_op == 4'hD);
               1: if (!(m_op inside {4'h5, 4'h7, 4'hD, 4'hE})) m_regs[m_rd] <= m_res;
               default: ;
            endcase
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("ready",     16'(instr_ready), 16'(!m_halt && m_cnt == 0));
      chk("alu_e",     16'(alu_e),       16'(m_alu_e));
      chk("illegal",   16'(illegal),     16'(m_ill));
      chk("out_valid", 16'(out_valid),   16'(m_ov));
      chk("halted",    16'(halted),      16'(m_halt));
      chk("opcode",    16'(opcode),      16'(m_op));
      chk("d",         16'(d),           16'(m_d));
      chk("alu_in_a",  alu_in_a,         m_a);
      chk("alu_in_b",  alu_in_b,         m_b);
      chk("out_data",  out_data,         m_od);
      chk("dbg_data",  dbg_data,         m_regs[dbg_addr]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single cycle; returns just after accept edge
   task automatic issue(input logic [15:0] w, input logic [15:0] din);
      instr = w; in_data = din; instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   task automatic peek(input string name, input logic [2:0] r, input logic [15:0] exp);
      dbg_addr = r;
      #1;
      chk(name, dbg_data, exp);
   endtask

   int halt_cycles;

   initial begin
      rst = 1'b1; instr = 16'h0; instr_valid = 1'b0; in_data = 16'h0; dbg_addr = 3'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", 16'(instr_ready), 16'h0001);
      chk("rst_alu_e", 16'(alu_e), 16'h0000);

      // IN R1 <- 0x1234
      issue(16'hC1C0, 16'h1234);
      chk("in_pre_e", 16'(alu_e), 16'h0000);
      tick();
      chk("in_alu_e", 16'(alu_e), 16'h0001);
      chk("in_opcode", 16'(opcode), 16'h000C);
      chk("in_a", alu_in_a, 16'h1234);
      tick(); tick();
      peek("in_r1", 3'd1, 16'h1234);

      // IN R2 <- 0x0001
      issue(16'hC2C0, 16'h0001);
      tick(); tick(); tick();
      peek("in_r2", 3'd2, 16'h0001);

      // ADD R1,R2 then dependent ADD R1,R2
      issue(16'hD100, 16'h0000);
      tick();
      chk("add_a", alu_in_a, 16'h1234);
      chk("add_b", alu_in_b, 16'h0001);
      tick(); tick();
      peek("add_r1", 3'd1, 16'h1235);
      issue(16'hD100, 16'h0000);
      tick();
      chk("add2_a", alu_in_a, 16'h1235);
      tick(); tick();
      peek("add2_r1", 3'd1, 16'h1236);

      // CMP R1,R2: strobe but no writeback
      issue(16'hD150, 16'h0000);
      tick();
      chk("cmp_alu_e", 16'(alu_e), 16'h0001);
      tick(); tick();
      peek("cmp_r1", 3'd1, 16'h1236);

      // OUT R1
      issue(16'hC8D0, 16'h0000);
      tick(); tick();
      chk("out_valid", 16'(out_valid), 16'h0001);
      chk("out_data", out_data, 16'h1236);
      tick();
      chk("out_valid_end", 16'(out_valid), 16'h0000);
      peek("out_r0", 3'd0, 16'h0000);

      // Illegal class
      issue(16'h0000, 16'h0000);
      chk("ill_pulse", 16'(illegal), 16'h0001);
      chk("ill_ready", 16'(instr_ready), 16'h0001);
      tick();
      chk("ill_end", 16'(illegal), 16'h0000);

      // HLT, then ignored instructions
      issue(16'hC0F0, 16'h0000);
      chk("hlt_halted", 16'(halted), 16'h0001);
      chk("hlt_ready", 16'(instr_ready), 16'h0000);
      instr = 16'hC1C0; in_data = 16'hFFFF; instr_valid = 1'b1;
      repeat (3) begin
         tick();
         chk("hlt_no_e", 16'(alu_e), 16'h0000);
      end
      instr_valid = 1'b0;
      peek("hlt_r1", 3'd1, 16'h1236);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("hlt_rst_halted", 16'(halted), 16'h0000);
      chk("hlt_rst_ready", 16'(instr_ready), 16'h0001);

      // Reset mid-EXEC abandons the write
      issue(16'hC1C0, 16'hABCD);
      tick();
      chk("mid_alu_e", 16'(alu_e), 16'h0001);
      rst = 1'b1;
      #1;
      chk("mid_rst_e", 16'(alu_e), 16'h0000);
      for (int r = 0; r < 8; r++) peek("mid_rst_reg", 3'(r), 16'h0000);
      tick();
      rst = 1'b0;
      tick(); tick(); tick();
      chk("mid_ready", 16'(instr_ready), 16'h0001);
      peek("mid_no_wb", 3'd1, 16'h0000);

      // Randomized traffic
      halt_cycles = 0;
      for (int n = 0; n < 4000; n++) begin
         instr[15:14] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         instr[13:8]  = 6'($urandom);
         instr[7:4]   = ($urandom_range(0, 40) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         instr[3:0]   = 4'($urandom);
         instr_valid  = ($urandom_range(0, 9) < 7);
         in_data      = 16'($urandom);
         dbg_addr     = 3'($urandom);
         halt_cycles  = m_halt ? halt_cycles + 1 : 0;
         if (halt_cycles > 6 || $urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            #2;
            rst = 1'b0;
            halt_cycles = 0;
         end
         tick();
      end
      instr_valid = 1'b0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
